fifo_syn_flex: RTL and testbench
================================

// Module: fifo_syn_flex
// PURPOSE
//  Single-clock, parametrised FIFO: next generation of the fifo_syn / fifo_asyn buffers.
//  Adds arbitrary (non-power-of-2) depth, selectable standard or first-word-fall-through (FWFT)
//  read mode, programmable almost-full/almost-empty, occupancy count, and overflow/underflow pulses.
//  Sits between a producer and a consumer in the same clock domain; flags drive back-pressure logic.
// PARAMETERS
//  FIFO_DWTH   4  data width, bits (>=1)
//  FIFO_DEPTH  6  number of storage words (>=2, need not be a power of 2)
//  FWFT        0  0 = standard read (registered dout, 1-cycle latency); 1 = first-word-fall-through
//  AF_LEVEL    5  almost_full asserted when data_cnt >= AF_LEVEL (1..FIFO_DEPTH)
//  AE_LEVEL    1  almost_empty asserted when data_cnt <= AE_LEVEL (0..FIFO_DEPTH-1)
//  CW = $clog2(FIFO_DEPTH+1) (localparam, count width)
// PORTS
//  clk           in   1          single clock, all logic on rising edge
//  rst_n         in   1          asynchronous reset, active low
//  din           in   FIFO_DWTH  write data
//  wren          in   1          write request
//  rden          in   1          read request (FWFT=1: pop/acknowledge of word on dout)
//  dout          out  FIFO_DWTH  read data
//  valid         out  1          dout holds a valid popped/presented word
//  full          out  1          data_cnt == FIFO_DEPTH
//  empty         out  1          data_cnt == 0
//  almost_full   out  1          data_cnt >= AF_LEVEL
//  almost_empty  out  1          data_cnt <= AE_LEVEL
//  data_cnt      out  CW         words stored, not yet popped
//  overflow      out  1          1-cycle pulse: a write was rejected
//  underflow     out  1          1-cycle pulse: a read was rejected
// BEHAVIOUR
//  - Reset (rst_n=0, async, any time incl. mid-burst): wr_ptr=rd_ptr=0, data_cnt=0, empty=1, full=0,
//    almost_empty=1, almost_full=0, dout=0, valid=0, overflow=0, underflow=0; storage not cleared.
//  - Write accept: wren && (!full || rd_accept). Read accept: rden && !empty.
//  - Accepted write: mem[wr_ptr]<=din; wr_ptr wraps FIFO_DEPTH-1 -> 0 (explicit compare, no pow-2 math).
//  - Accepted read: rd_ptr advances with the same wrap rule.
//  - data_cnt: +1 write only, -1 read only, unchanged for both or neither; flags derive from the
//    registered data_cnt, so they change on the edge that accepts the operation.
//  - Full + wren + rden same cycle: both accepted, data_cnt stays FIFO_DEPTH, no overflow.
//  - Empty + wren + rden same cycle: write accepted, read rejected (underflow=1), data_cnt -> 1.
//  - Rejected wren -> overflow=1 the following cycle only; rejected rden -> underflow=1 likewise.
//  - FWFT=0: accepted read at edge N loads dout<=mem[rd_ptr]; valid=1 for the cycle after edge N,
//    else 0; dout holds last value when no read. Read latency 1 cycle.
//  - FWFT=1: dout=mem[rd_ptr] continuously, valid=!empty; word written into an empty FIFO at edge N
//    is visible with valid=1 right after edge N; rden pops it at the next edge.
//  - Inputs assumed synchronous to clk; no internal CDC.
// TESTING (FIFO_DWTH=4, FIFO_DEPTH=6, AF=5, AE=1 unless stated)
//  1. Assert rst_n=0 mid-write-burst (cnt=3) -> outputs at reset values immediately; cnt=0, empty=1.
//  2. Write 1..6 -> almost_full after 5th, full after 6th, cnt=6; 7th write -> overflow pulse, cnt=6.
//  3. FWFT=0, read 7x from full -> dout 1..6, valid 1 cycle after each rden; 7th -> underflow, valid=0.
//  4. Write 4, read 4, write 6, read 6 -> order preserved across pointer wrap 5->0; empty at end.
//  5. Full + wren&rden -> cnt=6, full=1, no overflow; empty + wren&rden -> underflow pulse, cnt=1.
//  6. FWFT=1: write 0xA into empty -> valid=1, dout=0xA after that edge; rden -> valid=0, empty=1.

Source files
------------

// File: rtl/fifo_syn_flex.sv
// Single-clock FIFO with arbitrary depth, standard or first-word-fall-through
// read mode, programmable almost-full/almost-empty thresholds, an occupancy
// count and one-cycle overflow/underflow pulses for rejected requests.
module fifo_syn_flex #(
   parameter  int FIFO_DWTH  = 4,
   parameter  int FIFO_DEPTH = 6,
   parameter  int FWFT       = 0,
   parameter  int AF_LEVEL   = 5,
   parameter  int AE_LEVEL   = 1,
   localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [FIFO_DWTH-1:0] din,
   input  logic                 wren,
   input  logic                 rden,
   output logic [FIFO_DWTH-1:0] dout,
   output logic                 valid,
   output logic                 full,
   output logic                 empty,
   output logic                 almost_full,
   output logic                 almost_empty,
   output logic [CW-1:0]        data_cnt,
   output logic                 overflow,
   output logic                 underflow
);

   localparam int            PW       = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);

   logic [FIFO_DWTH-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0]        r_wr_ptr;
   logic [PW-1:0]        r_rd_ptr;
   logic [CW-1:0]        r_cnt;
   logic                 r_overflow;
   logic                 r_underflow;

   logic                 w_full;
   logic                 w_empty;
   logic                 w_rd_acc;
   logic                 w_wr_acc;
   logic [PW-1:0]        w_wr_ptr_nxt;
   logic [PW-1:0]        w_rd_ptr_nxt;
   logic [FIFO_DWTH-1:0] w_rd_word;

   // Flags come straight from the registered count, so they move on the
   // same edge that accepts the operation.
   assign w_full   = (r_cnt == DEPTH_C);
   assign w_empty  = (r_cnt == '0);

   // A write into a full FIFO is still taken when a read frees a slot
   // on the same edge.
   assign w_rd_acc = rden && !w_empty;
   assign w_wr_acc = wren && (!w_full || w_rd_acc);

   // Pointers wrap by explicit compare so any depth works.
   assign w_wr_ptr_nxt = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
   assign w_rd_ptr_nxt = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);

   assign w_rd_word = r_mem[r_rd_ptr];

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   // Write and read pointer advance on accepted operations.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= w_wr_ptr_nxt;
         end
         if (w_rd_acc) begin
            r_rd_ptr <= w_rd_ptr_nxt;
         end
      end
   end

   // Occupancy: simultaneous read and write cancel out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else begin
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Rejected requests produce a single-cycle pulse on the following cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_overflow  <= wren && !w_wr_acc;
         r_underflow <= rden && !w_rd_acc;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head word is presented continuously; blanked to zero when empty
         // so stale storage never appears on dout.
         always_comb begin
            dout  = w_empty ? '0 : w_rd_word;
            valid = !w_empty;
         end
      end else begin : g_std
         logic [FIFO_DWTH-1:0] r_dout;
         logic                 r_valid;

         // Registered read port: one-cycle latency, dout holds between reads.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_dout  <= '0;
               r_valid <= 1'b0;
            end else begin
               r_valid <= w_rd_acc;
               if (w_rd_acc) begin
                  r_dout <= w_rd_word;
               end
            end
         end

         assign dout  = r_dout;
         assign valid = r_valid;
      end
   endgenerate

   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (r_cnt >= AF_C);
   assign almost_empty = (r_cnt <= AE_C);
   assign data_cnt     = r_cnt;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_syn_flex.sv
// Bench for fifo_syn_flex: one standard-read instance and one FWFT instance,
// directed stimulus, expected read data queued at issue and checked by
// negedge monitors.
module tb_fifo_syn_flex;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic [3:0] din0 = '0, dout0;
   logic       wren0 = 1'b0, rden0 = 1'b0;
   logic       valid0, full0, empty0, af0, ae0, ovf0, unf0;
   logic [2:0] cnt0;

   logic [3:0] din1 = '0, dout1;
   logic       wren1 = 1'b0, rden1 = 1'b0;
   logic       valid1, full1, empty1, af1, ae1, ovf1, unf1;
   logic [2:0] cnt1;

   int         errors = 0;
   int         checks = 0;

   logic [3:0] mq0[$];
   logic [3:0] sq0[$];
   logic [3:0] mq1[$];

   always #5 clk = ~clk;

   fifo_syn_flex #(.FIFO_DWTH(4), .FIFO_DEPTH(6), .FWFT(0), .AF_LEVEL(5), .AE_LEVEL(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .din(din0), .wren(wren0), .rden(rden0),
      .dout(dout0), .valid(valid0), .full(full0), .empty(empty0),
      .almost_full(af0), .almost_empty(ae0), .data_cnt(cnt0),
      .overflow(ovf0), .underflow(unf0)
   );

   fifo_syn_flex #(.FIFO_DWTH(4), .FIFO_DEPTH(6), .FWFT(1), .AF_LEVEL(5), .AE_LEVEL(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .din(din1), .wren(wren1), .rden(rden1),
      .dout(dout1), .valid(valid1), .full(full1), .empty(empty1),
      .almost_full(af1), .almost_empty(ae1), .data_cnt(cnt1),
      .overflow(ovf1), .underflow(unf1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus on the standard-read instance; the queue model
   // decides acceptance and the flags expected after the edge.
   task automatic step0(input logic w, input logic r, input logic [3:0] d);
      logic ra, wa;
      int   n;
      ra = r && (mq0.size() > 0);
      wa = w && ((mq0.size() < 6) || ra);
      wren0 = w; rden0 = r; din0 = d;
      @(posedge clk);
      if (ra) sq0.push_back(mq0.pop_front());
      if (wa) mq0.push_back(d);
      #1;
      n = mq0.size();
      chk("overflow0",  ovf0,  w && !wa);
      chk("underflow0", unf0,  r && !ra);
      chk("cnt0",       cnt0,  n);
      chk("full0",      full0, n == 6);
      chk("empty0",     empty0, n == 0);
      chk("afull0",     af0,   n >= 5);
      chk("aempty0",    ae0,   n <= 1);
      wren0 = 1'b0; rden0 = 1'b0;
   endtask

   task automatic step1(input logic w, input logic r, input logic [3:0] d);
      logic ra, wa;
      int   n;
      ra = r && (mq1.size() > 0);
      wa = w && ((mq1.size() < 6) || ra);
      wren1 = w; rden1 = r; din1 = d;
      @(posedge clk);
      if (ra) void'(mq1.pop_front());
      if (wa) mq1.push_back(d);
      #1;
      n = mq1.size();
      chk("cnt1",       cnt1,   n);
      chk("empty1",     empty1, n == 0);
      chk("underflow1", unf1,   r && !ra);
      wren1 = 1'b0; rden1 = 1'b0;
   endtask

   // Standard-read monitor: valid must appear exactly one cycle after each
   // accepted read, carrying the next queued word.
   always @(negedge clk) begin
      logic [3:0] e;
      if (rst_n === 1'b1 && (valid0 === 1'b1 || sq0.size() > 0)) begin
         if (sq0.size() == 0) begin
            chk("valid0_spurious", valid0, 1'b0);
         end else begin
            e = sq0.pop_front();
            chk("valid0", valid0, 1'b1);
            if (valid0 === 1'b1) chk("dout0", dout0, e);
         end
      end
   end

   // FWFT monitor: the head of the model queue is always on dout.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("valid1", valid1, mq1.size() > 0);
         if (valid1 === 1'b1 && mq1.size() > 0) chk("dout1", dout1, mq1[0]);
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cnt0",   cnt0,   0);
      chk("rst_empty0", empty0, 1);
      chk("rst_full0",  full0,  0);
      chk("rst_ae0",    ae0,    1);
      chk("rst_af0",    af0,    0);
      chk("rst_valid0", valid0, 0);
      chk("rst_dout0",  dout0,  0);
      chk("rst_valid1", valid1, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Fill to full, then one write too many.
      for (int i = 1; i <= 6; i++) step0(1'b1, 1'b0, 4'(i));
      chk("t2_cnt",  cnt0,  6);
      chk("t2_full", full0, 1);
      step0(1'b1, 1'b0, 4'h7);
      chk("t2_ovf",  ovf0,  1);
      step0(1'b0, 1'b0, 4'h0);
      chk("t2_ovf_gone", ovf0, 0);

      // Drain with one read too many.
      for (int i = 0; i < 7; i++) step0(1'b0, 1'b1, 4'h0);
      chk("t3_unf", unf0, 1);
      step0(1'b0, 1'b0, 4'h0);
      chk("t3_valid_off", valid0, 0);

      // Pointer wrap.
      for (int i = 0; i < 4; i++) step0(1'b1, 1'b0, 4'(8 + i));
      for (int i = 0; i < 4; i++) step0(1'b0, 1'b1, 4'h0);
      for (int i = 0; i < 6; i++) step0(1'b1, 1'b0, 4'(4'hF - i));
      for (int i = 0; i < 6; i++) step0(1'b0, 1'b1, 4'h0);
      step0(1'b0, 1'b0, 4'h0);
      chk("t4_empty", empty0, 1);

      // Simultaneous read/write at full and at empty.
      for (int i = 0; i < 6; i++) step0(1'b1, 1'b0, 4'(2 * i + 1));
      step0(1'b1, 1'b1, 4'h4);
      chk("t5_full_cnt", cnt0, 6);
      chk("t5_full_ovf", ovf0, 0);
      for (int i = 0; i < 6; i++) step0(1'b0, 1'b1, 4'h0);
      step0(1'b1, 1'b1, 4'h3);
      chk("t5_empty_unf", unf0, 1);
      chk("t5_empty_cnt", cnt0, 1);
      step0(1'b0, 1'b1, 4'h0);
      step0(1'b1, 1'b0, 4'hC);
      step0(1'b0, 1'b0, 4'h0);

      // Asynchronous reset mid-burst (count at 3 with a write pending).
      for (int i = 0; i < 2; i++) step0(1'b1, 1'b0, 4'(5 + i));
      chk("t1_pre_cnt", cnt0, 3);
      wren0 = 1'b1; din0 = 4'h9;
      #3;
      rst_n = 1'b0;
      mq0.delete();
      sq0.delete();
      mq1.delete();
      #1;
      chk("t1_cnt",   cnt0,   0);
      chk("t1_empty", empty0, 1);
      chk("t1_full",  full0,  0);
      chk("t1_ae",    ae0,    1);
      chk("t1_af",    af0,    0);
      chk("t1_dout",  dout0,  0);
      chk("t1_valid", valid0, 0);
      chk("t1_ovf",   ovf0,   0);
      chk("t1_unf",   unf0,   0);
      wren0 = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("t1_post_cnt", cnt0, 0);

      // FWFT instance.
      step1(1'b1, 1'b0, 4'hA);
      chk("t6_valid", valid1, 1);
      chk("t6_dout",  dout1,  4'hA);
      step1(1'b1, 1'b0, 4'hB);
      chk("t6_hold",  dout1,  4'hA);
      step1(1'b0, 1'b1, 4'h0);
      chk("t6_next",  dout1,  4'hB);
      step1(1'b0, 1'b1, 4'h0);
      chk("t6_valid_off", valid1, 0);
      chk("t6_empty",     empty1, 1);
      step1(1'b0, 1'b1, 4'h0);
      chk("t6_unf", unf1, 1);

      step0(1'b0, 1'b0, 4'h0);
      chk("sq_drained", sq0.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
